sck_gen_prog: RTL and testbench
===============================

# sck_gen_prog

Programmable, burst-mode serial clock generator for the static-screen SPI path. It replaces the fixed free-running divider. It produces a run-time programmable SCK with selectable idle polarity for a counted number of bit periods. It also emits one-cycle leading and trailing edge strobes so the shift register can launch and sample data without re-detecting SCK edges. It sits between the Wishbone register file (divider, polarity, bit count, start) and the SPI shifter.

## Interface
- DIV_W, 8: width of the half-period divider value.
- NBITS_W, 6: width of the bit-count field; max burst length 2^NBITS_W-1 bits.
- clk_fpga  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- div  input  DIV_W  half-period minus one; half-period H = div+1 clk_fpga cycles.
- cpol  input  1  SCK idle level.
- nbits  input  NBITS_W  number of SCK periods in the burst.
- start  input  1  burst request; sampled only while idle.
- abort  input  1  synchronous burst cancel.
- sck  output  1  serial clock, registered.
- busy  output  1  burst in progress, registered.
- done  output  1  one-cycle pulse at normal burst completion.
- lead_stb  output  1  one-cycle strobe when sck makes its leading (idle to active) transition.
- trail_stb  output  1  one-cycle strobe when sck makes its trailing (active to idle) transition.

## Operation
- States: IDLE and RUN. busy = (state == RUN).
- IDLE:
  - sck is loaded with cpol every cycle, so it follows cpol with one cycle of lag.
  - On start=1 with nbits != 0: latch div, cpol and nbits; load the half-period counter with div and the edge counter with 2*nbits; go to RUN.
  - On start=1 with nbits == 0: stay in IDLE, pulse done next cycle, no sck activity.
- RUN:
  - If counter != 0, decrement it.
  - If counter == 0, toggle sck, reload the counter with the latched div, and decrement the edge counter.
  - A toggle away from the latched cpol asserts lead_stb. A toggle back to cpol asserts trail_stb.
  - When the final (2*nbits-th) toggle occurs: go to IDLE and pulse done in the same registered update.
- Inputs div, cpol and nbits are ignored during RUN. Only latched values apply.
- start during RUN is ignored; it is not queued.
- abort=1 in RUN: return to IDLE at the next edge, sck set to the latched cpol, strobes 0, done not asserted. abort in IDLE has no effect. abort has priority over a coincident final toggle.
- Edge counter width is NBITS_W+1, which prevents overflow of 2*nbits.

## Timing
- Reset values: sck=0, busy=0, done=0, lead_stb=0, trail_stb=0, state IDLE, counters 0. cpol is re-applied at the first clock edge after reset release.
- Cycle numbering: cycle 0 is the state after the edge that samples start.
  - busy=1 in cycles 0 to 2*nbits*H-1.
  - Leading transitions occur in cycles H, 3H, …, (2*nbits-1)H.
  - Trailing transitions occur in cycles 2H, 4H, …, 2*nbits*H.
- done=1 and busy=0 in cycle 2*nbits*H, coincident with the last trail_stb.
- Strobes are high in exactly the cycle where sck first shows its new level.
- Back-to-back bursts: start asserted in the done cycle is accepted. The next burst's cycle 0 immediately follows with no extra idle cycle.
- SCK frequency = f_clk / (2*(div+1)); div=0 gives f_clk/2 with 50% duty.
- An asynchronous reset mid-burst forces all outputs to their reset values immediately; no done is produced.

## Test plan
- Burst with div=1, cpol=0, nbits=3, start at cycle 0 -> lead_stb and sck rise in cycles 2, 6, 10; trail_stb and sck fall in cycles 4, 8, 12; done=1 and busy=0 in cycle 12.
- Fastest burst with div=0, cpol=1, nbits=1 -> sck=0 with lead_stb in cycle 1; sck=1 with trail_stb and done in cycle 2.
- Zero-length burst with nbits=0 and start -> done pulses once; busy and sck stay unchanged.
- Abort with div=3, nbits=4, abort in cycle 9 -> sck=cpol, busy=0, no done, no further strobes.
- Ignored inputs: change div, cpol and nbits and pulse start mid-burst -> waveform identical to an unchanged burst. Back-to-back start in the done cycle -> second burst begins in the next cycle.
- Mid-burst reset: assert rst_n=0 asynchronously in cycle 5 -> all outputs 0 without waiting for a clock edge. After release with cpol=1, sck=1 after the first edge.

Source files
------------

// File: rtl/sck_gen_prog_if.sv
// Control/status bundle between the register file (master) and the burst
// SCK generator (slave).
interface sck_gen_prog_if #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned NBITS_W = 6
);
    logic [DIV_W-1:0]   div;
    logic               cpol;
    logic [NBITS_W-1:0] nbits;
    logic               start;
    logic               abort;
    logic               sck;
    logic               busy;
    logic               done;
    logic               lead_stb;
    logic               trail_stb;

    modport master (
        output div, cpol, nbits, start, abort,
        input  sck, busy, done, lead_stb, trail_stb
    );

    modport slave (
        input  div, cpol, nbits, start, abort,
        output sck, busy, done, lead_stb, trail_stb
    );
endinterface

// File: rtl/sck_gen_prog.sv
// Burst-mode programmable SCK generator: counted SCK periods with selectable
// idle polarity, plus one-cycle leading/trailing edge strobes for the shifter.
module sck_gen_prog #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned NBITS_W = 6
) (
    input  logic           clk_fpga,
    input  logic           rst_n,
    sck_gen_prog_if.slave  bus
);
    localparam int unsigned ECNT_W = NBITS_W + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   hcnt_q;
    logic [ECNT_W-1:0]  ecnt_q;
    logic               cpol_q;
    logic               sck_q;
    logic               done_q;
    logic               lead_q;
    logic               trail_q;

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            hcnt_q  <= '0;
            ecnt_q  <= '0;
            cpol_q  <= 1'b0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q <= bus.cpol;
                    if (bus.start) begin
                        if (bus.nbits != '0) begin
                            div_q   <= bus.div;
                            cpol_q  <= bus.cpol;
                            hcnt_q  <= bus.div;
                            ecnt_q  <= {bus.nbits, 1'b0};
                            state_q <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a coincident final toggle: no done, no strobe.
                    if (bus.abort) begin
                        state_q <= IDLE;
                        sck_q   <= cpol_q;
                    end else if (hcnt_q != '0) begin
                        hcnt_q <= hcnt_q - DIV_W'(1);
                    end else begin
                        sck_q  <= ~sck_q;
                        hcnt_q <= div_q;
                        ecnt_q <= ecnt_q - ECNT_W'(1);
                        if (sck_q == cpol_q) begin
                            lead_q <= 1'b1;
                        end else begin
                            trail_q <= 1'b1;
                        end
                        if (ecnt_q == ECNT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sck       = sck_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.lead_stb  = lead_q;
    assign bus.trail_stb = trail_q;
endmodule

// File: tb/tb_sck_gen_prog.sv
// Scoreboard bench for sck_gen_prog: expected strobe/done events and per-cycle
// busy/sck levels are derived from the burst timing rules and checked at negedge.
module tb_sck_gen_prog;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int c;
        int k;
    } ev_t;

    ev_t sb[$];
    bit  exp_busy[int];
    bit  exp_sck[int];
    int  cur_end = 0;
    bit  cur_cpol = 1'b0;

    sck_gen_prog_if #(.DIV_W(8), .NBITS_W(6)) bus ();

    sck_gen_prog #(.DIV_W(8), .NBITS_W(6)) dut (
        .clk_fpga (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, act, req);
        end
    endtask

    function automatic string kname(input int k);
        return (k == 0) ? "lead_stb" : (k == 1) ? "trail_stb" : "done";
    endfunction

    // Monitor: pops expected events when the DUT shows a strobe; flags stale ones.
    always @(negedge clk) begin
        logic [2:0] act;
        act = {bus.done, bus.trail_stb, bus.lead_stb};
        while (sb.size() > 0 && sb[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing %s: actual absent at cycle %0d, required present", kname(sb[0].k), sb[0].c);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            if (act[k]) begin
                checks++;
                if (sb.size() > 0 && sb[0].c == cyc && sb[0].k == k) begin
                    void'(sb.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected %s: actual 1 at cycle %0d, required 0", kname(k), cyc);
                end
            end
        end
        check("busy", int'(bus.busy), int'(exp_busy.exists(cyc)));
        if (exp_sck.exists(cyc)) check("sck", int'(bus.sck), int'(exp_sck[cyc]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Issue a burst now; the edge that samples start leads to cycle 0 = cyc+1.
    task automatic issue(input int d, input bit p, input int n);
        int h;
        int t0;
        h  = d + 1;
        t0 = cyc + 1;
        bus.div   = 8'(d);
        bus.cpol  = p;
        bus.nbits = 6'(n);
        bus.start = 1'b1;
        if (n == 0) begin
            sb.push_back('{t0, 2});
            exp_sck[t0] = p;
            cur_end = t0;
        end else begin
            for (int c = 0; c <= 2 * n * h; c++) begin
                if (c < 2 * n * h) exp_busy[t0 + c] = 1'b1;
                exp_sck[t0 + c] = p ^ bit'((c / h) % 2);
            end
            for (int i = 1; i <= 2 * n; i++) sb.push_back('{t0 + i * h, (i % 2 == 1) ? 0 : 1});
            sb.push_back('{t0 + 2 * n * h, 2});
            cur_end = t0 + 2 * n * h;
        end
        cur_cpol = p;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_to_end(input bit noise);
        while (cyc < cur_end) begin
            if (noise && ($urandom_range(0, 2) == 0)) begin
                bus.div   = 8'($urandom);
                bus.cpol  = 1'($urandom);
                bus.nbits = 6'($urandom);
                bus.start = 1'($urandom);
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    // Abort driven in cycle cyc takes effect in cycle cyc+1.
    task automatic do_abort();
        int  j;
        ev_t keep[$];
        j = cyc + 1;
        bus.abort = 1'b1;
        for (int k = j; k <= cur_end; k++) begin
            exp_busy.delete(k);
            exp_sck.delete(k);
        end
        exp_sck[j] = cur_cpol;
        foreach (sb[i]) if (sb[i].c < j) keep.push_back(sb[i]);
        sb = keep;
        cur_end = j;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.div = '0; bus.cpol = 1'b0; bus.nbits = '0; bus.start = 1'b0; bus.abort = 1'b0;
        #3;
        check("reset_sck", int'(bus.sck), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_lead", int'(bus.lead_stb), 0);
        check("reset_trail", int'(bus.trail_stb), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        issue(1, 1'b0, 3);  run_to_end(1'b0); tick(); tick();
        issue(0, 1'b1, 1);  run_to_end(1'b0); tick(); tick();
        issue(2, 1'b0, 0);  tick(); tick();
        t0 = cyc;
        issue(3, 1'b0, 4);  wait_until(t0 + 1 + 9); do_abort(); tick(); tick();
        issue(2, 1'b1, 3);  run_to_end(1'b1);
        issue(1, 1'b0, 2);  run_to_end(1'b0); tick(); tick();

        // Asynchronous reset in cycle 5 of a burst, checked before the next edge.
        t0 = cyc;
        issue(1, 1'b0, 4);
        wait_until(t0 + 1 + 5);
        #1;
        rst_n = 1'b0;
        sb.delete(); exp_busy.delete(); exp_sck.delete();
        #1;
        check("arst_sck", int'(bus.sck), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_lead", int'(bus.lead_stb), 0);
        check("arst_trail", int'(bus.trail_stb), 0);
        bus.cpol = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_sck", int'(bus.sck), 1);
        tick();

        for (int b = 0; b < 30; b++) begin
            int d;
            int n;
            bit p;
            int mode;
            d = $urandom_range(0, 4);
            n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
            p = 1'($urandom);
            mode = $urandom_range(0, 3);
            t0 = cyc + 1;
            issue(d, p, n);
            if (n != 0 && mode == 0) begin
                wait_until(t0 + $urandom_range(0, 2 * n * (d + 1) - 1));
                do_abort();
                bus.abort = 1'($urandom);
                tick();
                bus.abort = 1'b0;
            end else begin
                run_to_end(mode == 1);
                if (mode != 2) tick();
            end
        end
        issue(0, 1'b0, 63); run_to_end(1'b0);
        tick(); tick(); tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
